uart_tx_arbiter: RTL and testbench

- Shares the single 8-bit UART transmitter between NREQ byte-stream requesters.
- Round-robin arbitration at packet granularity. A granted requester keeps the transmitter until it sends its last byte or hits the MAX_PKT limit.
- Drives the UART's TxBuf/Write_TxBuf inputs and paces writes using TxEmpty.
- Sits between on-chip message sources (status, debug, reply generators) and the UART.

---
 rtl/uart_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one UART transmitter among NREQ byte streams.
// Define UART_TX_ARB_HDR_EN to prefix every grant with a header byte HDR_BASE + grant index.
module uart_tx_arbiter #(
  parameter int         NREQ     = 4,
  parameter logic [7:0] MAX_PKT  = 8'd64
`ifdef UART_TX_ARB_HDR_EN
  ,parameter logic [7:0] HDR_BASE = 8'hA0
`endif
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   Req_Valid,
  input  logic [8*NREQ-1:0] Req_Data,
  input  logic [NREQ-1:0]   Req_Last,
  output logic [NREQ-1:0]   Req_Ack,
  output logic [7:0]        TxBuf,
  output logic              Write_TxBuf,
  input  logic              TxEmpty,
  output logic              Busy,
  output logic [2:0]        Grant
);

`ifdef UART_TX_ARB_HDR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, SEND = 2'd2, HDR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, SEND = 2'd2} state_t;
`endif

  state_t      state_r, state_s;
  logic [7:0]  txBuf_r, txBuf_s;
  logic        write_r, write_s;
  logic        busy_r, busy_s;
  logic [2:0]  grant_r, grant_s;
  logic [2:0]  rrPtr_r, rrPtr_s;
  logic [7:0]  count_r, count_s;
  logic        endGrant_r, endGrant_s;
  logic        grantValid_s, grantLast_s, ackFire_s;
  logic [7:0]  grantData_s;
  logic [2:0]  pick_s;

  // Mux the granted requester's valid/last/data out of the packed buses.
  always_comb begin
    grantValid_s = 1'b0;
    grantLast_s  = 1'b0;
    grantData_s  = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      grantValid_s = grantValid_s | (Req_Valid[i] & (grant_r == 3'(i)));
      grantLast_s  = grantLast_s  | (Req_Last[i]  & (grant_r == 3'(i)));
      grantData_s  = grantData_s  | (Req_Data[8*i +: 8] & {8{grant_r == 3'(i)}});
    end
  end

  // Round-robin pick: valid requester at the smallest distance above the pointer.
  always_comb begin
    int bestOff;
    int off;
    pick_s  = 3'd0;
    bestOff = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      off = (j >= int'(rrPtr_r)) ? (j - int'(rrPtr_r)) : (j - int'(rrPtr_r) + NREQ);
      if (Req_Valid[j] && (off < bestOff)) begin
        bestOff = off;
        pick_s  = 3'(j);
      end else begin
        bestOff = bestOff;
      end
    end
  end

  assign ackFire_s = Reset && (state_r == DATA) && TxEmpty && grantValid_s;

  // Acknowledge only the granted requester, and only when its byte is taken this cycle.
  always_comb begin
    Req_Ack = '0;
    if (ackFire_s) begin
      Req_Ack = {{(NREQ-1){1'b0}}, 1'b1} << grant_r;
    end else begin
      Req_Ack = '0;
    end
  end

  // Next-state and datapath decisions; the write strobe defaults low so it lasts exactly one cycle.
  always_comb begin
    state_s    = state_r;
    txBuf_s    = txBuf_r;
    write_s    = 1'b0;
    busy_s     = busy_r;
    grant_s    = grant_r;
    rrPtr_s    = rrPtr_r;
    count_s    = count_r;
    endGrant_s = endGrant_r;
    case (state_r)
      IDLE: begin
        if (|Req_Valid) begin
          grant_s    = pick_s;
          busy_s     = 1'b1;
          count_s    = 8'd0;
          endGrant_s = 1'b0;
`ifdef UART_TX_ARB_HDR_EN
          state_s    = HDR;
`else
          state_s    = DATA;
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      HDR: begin
        if (TxEmpty) begin
          txBuf_s    = HDR_BASE + {5'd0, grant_r};
          write_s    = 1'b1;
          endGrant_s = 1'b0;
          state_s    = SEND;
        end else begin
          state_s = HDR;
        end
      end
`endif
      DATA: begin
        if (ackFire_s) begin
          txBuf_s    = grantData_s;
          write_s    = 1'b1;
          count_s    = count_r + 8'd1;
          endGrant_s = grantLast_s | ((count_r + 8'd1) == MAX_PKT);
          state_s    = SEND;
        end else begin
          state_s = DATA;
        end
      end
      SEND: begin
        if (endGrant_r) begin
          busy_s  = 1'b0;
          rrPtr_s = (grant_r == 3'(NREQ-1)) ? 3'd0 : (grant_r + 3'd1);
          state_s = IDLE;
        end else begin
          state_s = DATA;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      txBuf_r    <= 8'd0;
      write_r    <= 1'b0;
      busy_r     <= 1'b0;
      grant_r    <= 3'd0;
      rrPtr_r    <= 3'd0;
      count_r    <= 8'd0;
      endGrant_r <= 1'b0;
    end else begin
      txBuf_r    <= txBuf_s;
      write_r    <= write_s;
      busy_r     <= busy_s;
      grant_r    <= grant_s;
      rrPtr_r    <= rrPtr_s;
      count_r    <= count_s;
      endGrant_r <= endGrant_s;
    end
  end

  assign TxBuf       = txBuf_r;
  assign Write_TxBuf = write_r;
  assign Busy        = busy_r;
  assign Grant       = grant_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packets against a packet-level model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int         NREQ    = 4;
  localparam logic [7:0] MAX_PKT = 8'd64;
`ifdef UART_TX_ARB_HDR_EN
  localparam logic [7:0] HDR_BASE = 8'hA0;
`endif

  typedef struct {
    logic [2:0] g;
    logic [7:0] b;
    bit         hdr;
  } expEntry_t;

  logic              clk = 1'b0;
  logic              Reset;
  logic [NREQ-1:0]   Req_Valid;
  logic [8*NREQ-1:0] Req_Data;
  logic [NREQ-1:0]   Req_Last;
  logic [NREQ-1:0]   Req_Ack;
  logic [7:0]        TxBuf;
  logic              Write_TxBuf;
  logic              TxEmpty;
  logic              Busy;
  logic [2:0]        Grant;

  logic [7:0] reqQ  [NREQ][$];
  bit         lastQ [NREQ][$];
  expEntry_t  expQ[$];

  int  errCnt, checkCnt;
  int  modelPtr, lockGrant, expData, acksSeen, writesSeen, sinceWrite, uartBusy;
  bit  modelLocked, holdLow, wroteNow;
  logic txEmptyPrev;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_PKT(MAX_PKT)) dut (
    .clk(clk), .Reset(Reset), .Req_Valid(Req_Valid), .Req_Data(Req_Data),
    .Req_Last(Req_Last), .Req_Ack(Req_Ack), .TxBuf(TxBuf), .Write_TxBuf(Write_TxBuf),
    .TxEmpty(TxEmpty), .Busy(Busy), .Grant(Grant)
  );

  task automatic checkVal(input string tag, input int obs, input int exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic pushByte(input int r, input logic [7:0] b, input bit l);
    reqQ[r].push_back(b);
    lastQ[r].push_back(l);
  endtask

  // Packet-level model: round robin over whole packets, chunked at MAX_PKT, pointer moves past the served requester.
  task automatic buildExpected();
    logic [7:0] cb [NREQ][$];
    bit         cl [NREQ][$];
    expEntry_t  e;
    int g, cnt;
    bit found, done, l;
    expData = 0; acksSeen = 0; writesSeen = 0;
    for (int i = 0; i < NREQ; i++) begin
      cb[i] = reqQ[i];
      cl[i] = lastQ[i];
    end
    found = 1'b1;
    while (found && !modelLocked) begin
      found = 1'b0; g = 0;
      for (int k = NREQ-1; k >= 0; k--) begin
        if (cb[(modelPtr + k) % NREQ].size() > 0) begin
          g = (modelPtr + k) % NREQ;
          found = 1'b1;
        end
      end
      if (found) begin
`ifdef UART_TX_ARB_HDR_EN
        e.g = 3'(g); e.b = HDR_BASE + 8'(g); e.hdr = 1'b1;
        expQ.push_back(e);
`endif
        cnt = 0; done = 1'b0;
        while (!done) begin
          if (cb[g].size() == 0) begin
            modelLocked = 1'b1; lockGrant = g; done = 1'b1;
          end else begin
            e.b = cb[g].pop_front(); l = cl[g].pop_front();
            e.g = 3'(g); e.hdr = 1'b0;
            expQ.push_back(e);
            cnt++; expData++;
            if (l || cnt == int'(MAX_PKT)) done = 1'b1;
          end
        end
        if (!modelLocked) modelPtr = (g + 1) % NREQ;
      end
    end
  endtask

  // One clock: check outputs, run the UART and requester models, then observe the acknowledge.
  task automatic tick();
    expEntry_t e;
    int ackIdx;
    logic [7:0] dummyB;
    bit dummyL;
    @(negedge clk);
    wroteNow = 1'b0;
    sinceWrite++;
    if (Write_TxBuf === 1'b1) begin
      wroteNow = 1'b1;
      writesSeen++;
      checkVal("wr_spacing", int'(sinceWrite >= 2), 1);
      checkVal("wr_txempty", int'(txEmptyPrev), 1);
      sinceWrite = 0;
      uartBusy = $urandom_range(1, 6);
      if (expQ.size() == 0) begin
        checkVal("unexpected_write", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkVal("tx_byte", int'(TxBuf), int'(e.b));
        checkVal("tx_grant", int'(Grant), int'(e.g));
      end
    end
    TxEmpty = !holdLow && (uartBusy == 0);
    if (uartBusy > 0) uartBusy--;
    txEmptyPrev = TxEmpty;
    for (int i = 0; i < NREQ; i++) begin
      Req_Valid[i]       = reqQ[i].size() > 0;
      Req_Data[8*i +: 8] = (reqQ[i].size() > 0) ? reqQ[i][0] : 8'h00;
      Req_Last[i]        = (lastQ[i].size() > 0) ? lastQ[i][0] : 1'b0;
    end
    #1;
    if (Req_Ack !== '0) begin
      acksSeen++;
      ackIdx = 0;
      checkVal("ack_onehot", $countones(Req_Ack), 1);
      checkVal("ack_txempty", int'(TxEmpty), 1);
      for (int i = 0; i < NREQ; i++) if (Req_Ack[i]) ackIdx = i;
      if (expQ.size() == 0 || expQ[0].hdr) checkVal("ack_unexpected", 1, 0);
      else checkVal("ack_grant", ackIdx, int'(expQ[0].g));
      if (reqQ[ackIdx].size() > 0) begin
        dummyB = reqQ[ackIdx].pop_front();
        dummyL = lastQ[ackIdx].pop_front();
      end
    end
  endtask

  task automatic runPhase(input int budget, input string name);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checkVal({name, "_timeout"}, expQ.size(), 0);
    repeat (3) tick();
    checkVal({name, "_acks"}, acksSeen, expData);
    if (modelLocked) begin
      checkVal({name, "_lock_busy"}, int'(Busy), 1);
      checkVal({name, "_lock_grant"}, int'(Grant), lockGrant);
    end else begin
      checkVal({name, "_busy_end"}, int'(Busy), 0);
    end
  endtask

  task automatic applyReset();
    Reset = 1'b0;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      reqQ[i].delete();
      lastQ[i].delete();
    end
    expQ.delete();
    modelPtr = 0; modelLocked = 1'b0; sinceWrite = 100;
    repeat (2) tick();
    Reset = 1'b1;
    tick();
  endtask

  initial begin
    int n, np, len;
    bit any;
    errCnt = 0; checkCnt = 0; modelPtr = 0; modelLocked = 1'b0; lockGrant = 0;
    sinceWrite = 100; uartBusy = 0; holdLow = 1'b0; txEmptyPrev = 1'b1;
    expData = 0; acksSeen = 0; writesSeen = 0;

    Reset = 1'b0; TxEmpty = 1'b1; Req_Valid = '1; Req_Data = {NREQ{8'h5A}}; Req_Last = '0;
    #2;
    checkVal("rst_ack", int'(Req_Ack), 0);
    checkVal("rst_txbuf", int'(TxBuf), 0);
    checkVal("rst_write", int'(Write_TxBuf), 0);
    checkVal("rst_busy", int'(Busy), 0);
    checkVal("rst_grant", int'(Grant), 0);
    Req_Valid = '0;
    tick(); tick();
    Reset = 1'b1;
    tick();

    pushByte(0, 8'h11, 1'b0); pushByte(0, 8'h22, 1'b0); pushByte(0, 8'h33, 1'b1);
    buildExpected();
    runPhase(500, "three_bytes");
`ifndef UART_TX_ARB_HDR_EN
    checkVal("three_bytes_writes", writesSeen, 3);
`endif

    pushByte(0, 8'h44, 1'b1); pushByte(1, 8'h55, 1'b1);
    buildExpected();
    checkVal("rr_model_first", int'(expQ[0].g), 1);
    runPhase(500, "rr_after_0");

    applyReset();
    for (int r = 0; r < 3; r++) begin
      pushByte(r, 8'(8'h10 * (r + 1)), 1'b0);
      pushByte(r, 8'(8'h10 * (r + 1) + 1), 1'b1);
    end
    buildExpected();
    runPhase(500, "three_reqs");

    for (int k = 1; k <= 70; k++) pushByte(3, 8'(k), 1'b0);
    pushByte(1, 8'hB1, 1'b0); pushByte(1, 8'hB2, 1'b0); pushByte(1, 8'hB3, 1'b1);
    buildExpected();
    runPhase(5000, "max_pkt");

    applyReset();
    holdLow = 1'b1;
    pushByte(2, 8'h5C, 1'b1);
    buildExpected();
    n = 0;
    repeat (500) begin
      tick();
      if (wroteNow) n++;
    end
    checkVal("hold_writes", n, 0);
    checkVal("hold_acks", acksSeen, 0);
    checkVal("hold_busy", int'(Busy), 1);
    checkVal("hold_grant", int'(Grant), 2);
    holdLow = 1'b0;
    tick();
`ifndef UART_TX_ARB_HDR_EN
    checkVal("release_ack", acksSeen, 1);
`endif
    tick();
    checkVal("release_write", int'(wroteNow), 1);
    runPhase(500, "hold");

    pushByte(1, 8'hC1, 1'b0); pushByte(1, 8'hC2, 1'b0); pushByte(1, 8'hC3, 1'b0); pushByte(1, 8'hC4, 1'b1);
    buildExpected();
    n = 0;
    while (writesSeen < 2 && n < 500) begin
      tick();
      n++;
    end
    checkVal("midrst_reach", writesSeen, 2);
    Reset = 1'b0;
    #1;
    checkVal("midrst_write", int'(Write_TxBuf), 0);
    checkVal("midrst_busy", int'(Busy), 0);
    checkVal("midrst_grant", int'(Grant), 0);
    checkVal("midrst_ack", int'(Req_Ack), 0);
    applyReset();
    pushByte(1, 8'hD1, 1'b1); pushByte(0, 8'hD0, 1'b1);
    buildExpected();
    runPhase(500, "after_rst");

    for (int r = 0; r < 6; r++) begin
      any = 1'b0;
      for (int q = 0; q < NREQ; q++) begin
        if ($urandom_range(0, 1) == 1) begin
          np = $urandom_range(1, 2);
          for (int p = 0; p < np; p++) begin
            len = $urandom_range(1, 70);
            for (int k = 0; k < len; k++) pushByte(q, 8'($urandom), k == len - 1);
          end
          any = 1'b1;
        end
      end
      if (!any) pushByte(0, 8'($urandom), 1'b1);
      buildExpected();
      runPhase(20000, "rand");
    end

`ifdef UART_TX_ARB_HDR_EN
    pushByte(2, 8'hAA, 1'b1);
    buildExpected();
    checkVal("hdr_first", int'(expQ[0].b), 8'hA2);
    runPhase(500, "hdr");
    checkVal("hdr_writes", writesSeen, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
